// File: rtl/synapse_current_driver.sv
// Current-based synapse: each presynaptic spike adds a programmable weight
// (saturating at 8'hFF), and between spikes the current decays exponentially
// through a periodic shift-subtract tick. The output feeds the LIF neuron's
// synaptic current input.
module synapse_current_driver #(
  parameter logic [7:0] INIT_WEIGHT  = 8'h20,
  parameter int         DECAY_SHIFT  = 2,
  parameter int         DECAY_PERIOD = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pre_spike,
  input  logic [7:0] weight_in,
  input  logic       weight_we,
  input  logic       count_clr,
  output logic [7:0] synaptic_current,
  output logic       active,
  output logic       sat,
  output logic [7:0] spike_count
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  localparam logic [7:0] PERIOD_LAST = 8'(DECAY_PERIOD - 1);

  state_t     state;
  logic [7:0] weight;
  logic [7:0] prescaler;
  logic [7:0] shifted;
  logic [7:0] decayed;
  logic [8:0] sum;
  logic [7:0] next_current;
  logic       tick;
  logic       clip;

  // Decay first, then add the spike weight with a 9-bit sum so overflow is visible.
  // A shift that rounds to zero still removes one LSB so the current always reaches 0.
  always_comb begin
    tick         = (state == ACTIVE) && (prescaler == PERIOD_LAST);
    shifted      = synaptic_current >> DECAY_SHIFT;
    decayed      = synaptic_current;
    if (tick) begin
      if (shifted == 8'h00 && synaptic_current != 8'h00)
        decayed = synaptic_current - 8'h01;
      else
        decayed = synaptic_current - shifted;
    end
    sum          = {1'b0, decayed} + {1'b0, weight};
    clip         = pre_spike && sum[8];
    next_current = decayed;
    if (pre_spike)
      next_current = sum[8] ? 8'hFF : sum[7:0];
  end

  // Current, state, prescaler and the saturation pulse; the prescaler only runs while ACTIVE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      active           <= 1'b0;
      synaptic_current <= 8'h00;
      prescaler        <= 8'h00;
      sat              <= 1'b0;
    end else begin
      synaptic_current <= next_current;
      sat              <= clip;
      if (next_current == 8'h00) begin
        state     <= IDLE;
        active    <= 1'b0;
        prescaler <= 8'h00;
      end else begin
        state  <= ACTIVE;
        active <= 1'b1;
        if (state == ACTIVE)
          prescaler <= tick ? 8'h00 : prescaler + 8'h01;
        else
          prescaler <= 8'h00;
      end
    end
  end

  // Weight register; a spike in the same cycle as a write still sees the old weight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      weight <= INIT_WEIGHT;
    else if (weight_we)
      weight <= weight_in;
  end

  // Saturating spike counter; a clear takes priority over a coincident spike.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      spike_count <= 8'h00;
    else if (count_clr)
      spike_count <= 8'h00;
    else if (pre_spike && spike_count != 8'hFF)
      spike_count <= spike_count + 8'h01;
  end

endmodule

// File: tb/tb_synapse_current_driver.sv
// Scoreboard bench for synapse_current_driver: a behavioural model predicts the
// outputs for every driven cycle, expectations are queued at drive time and
// popped after the following rising edge. Directed constant checks cover the
// decay waveform, saturation, weight-write race, counter and reset scenarios.
module tb_synapse_current_driver;

  localparam int SHIFT  = 2;
  localparam int PERIOD = 4;

  logic       clk;
  logic       rst_n;
  logic       pre_spike;
  logic [7:0] weight_in;
  logic       weight_we;
  logic       count_clr;
  logic [7:0] synaptic_current;
  logic       active;
  logic       sat;
  logic [7:0] spike_count;

  typedef struct {
    int cur;
    int act;
    int sat;
    int cnt;
  } expect_t;

  expect_t scoreQ[$];

  int checkCount = 0;
  int errorCount = 0;

  // behavioural model state
  int mCur, mAct, mPre, mWeight, mCnt, mSat;

  synapse_current_driver #(
    .INIT_WEIGHT(8'h20),
    .DECAY_SHIFT(SHIFT),
    .DECAY_PERIOD(PERIOD)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .pre_spike(pre_spike),
    .weight_in(weight_in),
    .weight_we(weight_we),
    .count_clr(count_clr),
    .synaptic_current(synaptic_current),
    .active(active),
    .sat(sat),
    .spike_count(spike_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    mCur = 0; mAct = 0; mPre = 0; mWeight = 'h20; mCnt = 0; mSat = 0;
  endtask

  // advance the model by one clock using the spec arithmetic
  task automatic modelStep(input int spike, input int we, input int win, input int clr);
    int d, s, nxt;
    bit tk;
    tk = (mAct == 1) && (mPre == PERIOD - 1);
    d  = mCur;
    if (tk) begin
      if ((mCur / (1 << SHIFT)) == 0 && mCur != 0) d = mCur - 1;
      else d = mCur - (mCur / (1 << SHIFT));
    end
    nxt  = d;
    mSat = 0;
    if (spike != 0) begin
      s = d + mWeight;
      if (s > 255) begin nxt = 255; mSat = 1; end
      else nxt = s;
    end
    if (nxt == 0) begin
      mAct = 0; mPre = 0;
    end else begin
      if (mAct == 1) mPre = tk ? 0 : mPre + 1;
      else mPre = 0;
      mAct = 1;
    end
    mCur = nxt;
    if (we != 0) mWeight = win;
    if (clr != 0) mCnt = 0;
    else if (spike != 0 && mCnt < 255) mCnt = mCnt + 1;
  endtask

  // drive one cycle, queue the prediction, then compare after the edge
  task automatic applyStimulus(input int spike, input int we, input int win, input int clr);
    expect_t e;
    pre_spike = spike[0];
    weight_we = we[0];
    weight_in = win[7:0];
    count_clr = clr[0];
    modelStep(spike, we, win, clr);
    e.cur = mCur; e.act = mAct; e.sat = mSat; e.cnt = mCnt;
    scoreQ.push_back(e);
    @(posedge clk);
    #1;
    pre_spike = 1'b0;
    weight_we = 1'b0;
    count_clr = 1'b0;
    if (scoreQ.size() == 0) begin
      checkOutput("queueEmpty", 1, 0);
    end else begin
      e = scoreQ.pop_front();
      checkOutput("current", int'(synaptic_current), e.cur);
      checkOutput("active", int'(active), e.act);
      checkOutput("sat", int'(sat), e.sat);
      checkOutput("spikeCount", int'(spike_count), e.cnt);
    end
  endtask

  task automatic drainIdle();
    for (int i = 0; i < 300 && (mCur != 0 || mAct != 0); i++)
      applyStimulus(0, 0, 0, 0);
    checkOutput("drained", int'(synaptic_current), 0);
  endtask

  logic [7:0] decayTbl [13];

  initial begin
    decayTbl = '{8'h18, 8'h12, 8'h0E, 8'h0B, 8'h09, 8'h07, 8'h06,
                 8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h00};
    rst_n = 1'b0; pre_spike = 1'b0; weight_in = 8'h00; weight_we = 1'b0; count_clr = 1'b0;
    modelReset();
    #1;
    checkOutput("resetCurrent", int'(synaptic_current), 0);
    checkOutput("resetActive", int'(active), 0);
    checkOutput("resetSat", int'(sat), 0);
    checkOutput("resetCount", int'(spike_count), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // single spike with default weight, then the full decay waveform
    applyStimulus(1, 0, 0, 0);
    checkOutput("spikeDefault", int'(synaptic_current), 'h20);
    checkOutput("spikeActive", int'(active), 1);
    for (int k = 0; k < 13; k++) begin
      repeat (4) applyStimulus(0, 0, 0, 0);
      checkOutput("decayStep", int'(synaptic_current), int'(decayTbl[k]));
    end
    checkOutput("decayIdle", int'(active), 0);

    // coincident tick and spike: 0x18 - 0x06 + 0x20
    applyStimulus(1, 0, 0, 0);
    repeat (4) applyStimulus(0, 0, 0, 0);
    checkOutput("preTick", int'(synaptic_current), 'h18);
    repeat (3) applyStimulus(0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    checkOutput("tickAndSpike", int'(synaptic_current), 'h32);
    drainIdle();

    // weight write race: same-cycle spike uses old weight
    applyStimulus(1, 1, 'h50, 0);
    checkOutput("raceOldWeight", int'(synaptic_current), 'h20);
    applyStimulus(1, 0, 0, 0);
    checkOutput("raceNewWeight", int'(synaptic_current), 'h70);
    drainIdle();

    // saturation with weight 0xC0
    applyStimulus(0, 1, 'hC0, 1);
    applyStimulus(1, 0, 0, 0);
    checkOutput("satFirst", int'(synaptic_current), 'hC0);
    checkOutput("satFirstFlag", int'(sat), 0);
    applyStimulus(1, 0, 0, 0);
    checkOutput("satClip", int'(synaptic_current), 'hFF);
    checkOutput("satFlag", int'(sat), 1);
    applyStimulus(0, 0, 0, 0);
    checkOutput("satPulseEnd", int'(sat), 0);
    checkOutput("satCount", int'(spike_count), 2);
    drainIdle();

    // zero weight: current unchanged, spike still counted
    applyStimulus(0, 1, 0, 1);
    applyStimulus(1, 0, 0, 0);
    checkOutput("zeroWeightCur", int'(synaptic_current), 0);
    checkOutput("zeroWeightAct", int'(active), 0);
    checkOutput("zeroWeightCnt", int'(spike_count), 1);

    // counter saturation and clear-wins
    applyStimulus(0, 1, 'h01, 1);
    repeat (300) applyStimulus(1, 0, 0, 0);
    checkOutput("countSat", int'(spike_count), 'hFF);
    applyStimulus(1, 0, 0, 1);
    checkOutput("countClrWins", int'(spike_count), 0);
    drainIdle();

    // asynchronous reset mid-run at current 0x40
    applyStimulus(0, 1, 'h40, 0);
    applyStimulus(1, 0, 0, 0);
    checkOutput("preReset", int'(synaptic_current), 'h40);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("asyncCurrent", int'(synaptic_current), 0);
    checkOutput("asyncActive", int'(active), 0);
    checkOutput("asyncSat", int'(sat), 0);
    checkOutput("asyncCount", int'(spike_count), 0);
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    applyStimulus(1, 0, 0, 0);
    checkOutput("postResetWeight", int'(synaptic_current), 'h20);
    drainIdle();

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
